// File: rtl/div_unit_pkg.sv
// Shared CPU definitions used by the divider: operation encodings, FSM states and helpers.
package div_unit_pkg;

  typedef enum logic [1:0] {
    DIV_OP  = 2'b00,
    DIVU_OP = 2'b01,
    REM_OP  = 2'b10,
    REMU_OP = 2'b11
  } div_ctrl_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } div_state_e;

  localparam int unsigned DIV_ITERS = 32;
  localparam int unsigned CNT_W     = 5;

  function automatic logic op_is_signed(input div_ctrl_e op);
    return (op == DIV_OP) || (op == REM_OP);
  endfunction

  function automatic logic op_is_rem(input div_ctrl_e op);
    return (op == REM_OP) || (op == REMU_OP);
  endfunction

endpackage

// File: rtl/div_unit.sv
// Iterative 32-bit restoring divider (DIV/DIVU/REM/REMU), one quotient bit per clock.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// ST_IDLE | ready for a request; ready_o=1
// ST_CALC | iterating on operand magnitudes, 32 edges
// ST_DONE | result on data_o, valid_o=1 for this one cycle
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  input  logic [1:0]       DivCtrl_i,
  input  logic             flush_i,
  output logic             ready_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  div_state_e state, state_nxt;

  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] quo, rem, dvsr, data_q;
  div_ctrl_e        op_q;
  logic             neg_q, neg_r;

  div_ctrl_e        op_in;
  logic             in_signed, in_rem;
  logic             accept, div_zero, ovf, special;
  logic [WIDTH-1:0] abs_a, abs_b, special_res;

  logic [WIDTH:0]   rem_sh, diff;
  logic [WIDTH-1:0] step_q, step_r, result;

  // Request decode and early-out detection
  always_comb begin
    op_in       = div_ctrl_e'(DivCtrl_i);
    in_signed   = op_is_signed(op_in);
    in_rem      = op_is_rem(op_in);
    accept      = valid_i && (state == ST_IDLE) && !flush_i;
    div_zero    = (data2_i == '0);
    ovf         = in_signed && (data1_i == {1'b1, {(WIDTH-1){1'b0}}}) && (data2_i == '1);
    special     = div_zero || ovf;
    abs_a       = (in_signed && data1_i[WIDTH-1]) ? -data1_i : data1_i;
    abs_b       = (in_signed && data2_i[WIDTH-1]) ? -data2_i : data2_i;
    special_res = '0;
    if (div_zero)
      special_res = in_rem ? data1_i : '1;
    else
      special_res = in_rem ? '0 : data1_i;
  end

  // One restoring step; the remainder stays below the divisor, so W+1 bits suffice
  always_comb begin
    rem_sh = {rem, quo[WIDTH-1]};
    diff   = rem_sh - {1'b0, dvsr};
    step_q = {quo[WIDTH-2:0], ~diff[WIDTH]};
    step_r = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
    result = op_is_rem(op_q) ? (neg_r ? -step_r : step_r)
                             : (neg_q ? -step_q : step_q);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) state_nxt = special ? ST_DONE : ST_CALC;
      end
      ST_CALC: begin
        if (flush_i)         state_nxt = ST_IDLE;
        else if (cnt == '0)  state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    ready_o = (state == ST_IDLE);
    valid_o = (state == ST_DONE);
    data_o  = data_q;
  end

  // Datapath; data_q changes only on accept (early-out) or on the final iteration
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt    <= '0;
      quo    <= '0;
      rem    <= '0;
      dvsr   <= '0;
      op_q   <= DIV_OP;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      data_q <= '0;
    end else if (accept) begin
      cnt    <= CNT_W'(DIV_ITERS - 1);
      quo    <= abs_a;
      rem    <= '0;
      dvsr   <= abs_b;
      op_q   <= op_in;
      neg_q  <= in_signed && (data1_i[WIDTH-1] ^ data2_i[WIDTH-1]);
      neg_r  <= in_signed && data1_i[WIDTH-1];
      if (special) data_q <= special_res;
    end else if ((state == ST_CALC) && !flush_i) begin
      quo <= step_q;
      rem <= step_r;
      if (cnt == '0) data_q <= result;
      else           cnt    <= cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: stimulus pushes expected result and arrival cycle, monitor pops on valid_o.
module tb_div_unit;

  logic        clk;
  logic        rst_i;
  logic        valid_i;
  logic [31:0] data1_i, data2_i;
  logic [1:0]  DivCtrl_i;
  logic        flush_i;
  logic        ready_o, valid_o;
  logic [31:0] data_o;

  div_unit #(.WIDTH(32)) dut (
    .clk_i    (clk),
    .rst_i    (rst_i),
    .valid_i  (valid_i),
    .data1_i  (data1_i),
    .data2_i  (data2_i),
    .DivCtrl_i(DivCtrl_i),
    .flush_i  (flush_i),
    .ready_o  (ready_o),
    .valid_o  (valid_o),
    .data_o   (data_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst_i === 1'b1 && valid_o === 1'b1) begin
      exp_t e;
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_valid: got data 0x%08h at cycle %0d, expected no result", data_o, cyc);
      end else begin
        e = sb.pop_front();
        check("result_data", data_o, e.data);
        check("result_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic wait_drain();
    for (int i = 0; i < 60 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      n_vec++;
      n_err++;
      $display("FAIL timeout: got %0d pending results, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    valid_i   = 1'b1;
    DivCtrl_i = op;
    data1_i   = a;
    data2_i   = b;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    data1_i = 32'h0BAD_F00D;
    data2_i = 32'h0;
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    @(negedge clk);
    check("ready_idle", {31'b0, ready_o}, 32'd1);
    issue(v.op, v.a, v.b);
    e.data = v.exp;
    e.cyc  = cyc + v.lat;
    sb.push_back(e);
    wait_drain();
  endtask

  localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

  vec_t vecs[] = '{
    '{OP_DIV,  32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 32},
    '{OP_REM,  32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32},
    '{OP_REMU, 32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0001, 32},
    '{OP_DIVU, 32'hFFFF_FFF9, 32'h0000_0002, 32'h7FFF_FFFC, 32},
    '{OP_DIVU, 32'h0000_0064, 32'h0000_0000, 32'hFFFF_FFFF, 0},
    '{OP_REMU, 32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 0},
    '{OP_DIV,  32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFF, 0},
    '{OP_REM,  32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 0},
    '{OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0},
    '{OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 0},
    '{OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32},
    '{OP_REMU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32},
    '{OP_DIV,  32'h8000_0000, 32'h0000_0002, 32'hC000_0000, 32},
    '{OP_DIVU, 32'h0000_0064, 32'h0000_0007, 32'h0000_000E, 32},
    '{OP_REMU, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32},
    '{OP_DIV,  32'h0000_0064, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32},
    '{OP_REM,  32'h0000_0064, 32'hFFFF_FFF9, 32'h0000_0002, 32},
    '{OP_DIV,  32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'h0000_000E, 32},
    '{OP_REM,  32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32},
    '{OP_DIV,  32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 32},
    '{OP_DIV,  32'h0000_0000, 32'h0000_0005, 32'h0000_0000, 32}
  };

  initial begin
    exp_t e;
    rst_i     = 1'b0;
    valid_i   = 1'b0;
    flush_i   = 1'b0;
    DivCtrl_i = 2'b00;
    data1_i   = '0;
    data2_i   = '0;

    #12;
    check("reset_ready", {31'b0, ready_o}, 32'd1);
    check("reset_valid", {31'b0, valid_o}, 32'd0);
    check("reset_data", data_o, 32'h0);

    // First edge after release must accept
    @(negedge clk);
    rst_i     = 1'b1;
    valid_i   = 1'b1;
    DivCtrl_i = OP_DIVU;
    data1_i   = 32'd200;
    data2_i   = 32'd9;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    e.data  = 32'd22;
    e.cyc   = cyc + 32;
    sb.push_back(e);
    wait_drain();

    foreach (vecs[i]) run_vec(vecs[i]);

    // Flush at E10 abandons the operation
    issue(OP_DIVU, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush_i = 1'b1;
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    check("flush_ready", {31'b0, ready_o}, 32'd1);
    repeat (30) @(posedge clk);
    run_vec('{OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 32});

    // Flush wins over valid in IDLE
    @(negedge clk);
    valid_i   = 1'b1;
    flush_i   = 1'b1;
    DivCtrl_i = OP_DIVU;
    data1_i   = 32'd100;
    data2_i   = 32'd0;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    flush_i = 1'b0;
    check("flush_prio_ready", {31'b0, ready_o}, 32'd1);
    repeat (40) @(posedge clk);

    // Asynchronous reset mid-CALC
    issue(OP_DIV, 32'hFFFF_FF9C, 32'hFFFF_FFF9);
    repeat (5) @(posedge clk);
    #3;
    rst_i = 1'b0;
    #1;
    check("async_rst_valid", {31'b0, valid_o}, 32'd0);
    check("async_rst_data", data_o, 32'h0);
    check("async_rst_ready", {31'b0, ready_o}, 32'd1);
    @(negedge clk);
    rst_i = 1'b1;
    repeat (40) @(posedge clk);
    run_vec('{OP_REMU, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32});

    @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
